// File: rtl/tt_colorflyx_uart_pkg.sv
// Shared types and constants for the colorflyx checksum UART transmitter.
package tt_colorflyx_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned BIT_IDX_W   = $clog2(DATA_BITS);
    localparam logic [7:0]  UIO_OE_MASK = 8'b0000_1110;

    localparam int unsigned START_BIT = 0;
    localparam int unsigned TX_BIT    = 1;
    localparam int unsigned BUSY_BIT  = 2;
    localparam int unsigned DONE_BIT  = 3;

endpackage

// File: rtl/colorflyx_sync_edge.sv
// Two-flop synchroniser for an asynchronous strobe followed by a registered
// one-cycle rising-edge pulse.
module colorflyx_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/tt_um_colorflyx_sum_uart_tx.sv
// TinyTapeout UART 8N1 transmitter with a running modulo-256 checksum on uo_out.
// Define COLORFLYX_UART_PARITY_EN to insert an even-parity bit (8E1 frame).
module tt_um_colorflyx_sum_uart_tx
    import tt_colorflyx_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [7:0]             data_q, data_d;
    logic [7:0]             checksum_q, checksum_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   launch;
    logic                   baud_done;

    colorflyx_sync_edge u_start_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (uio_in[START_BIT]),
        .rise_o  (launch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            checksum_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            checksum_q <= checksum_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state: tx_d is the level for the bit being entered, so tx is registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        checksum_d = checksum_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        baud_done  = (cnt_q == '0);

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d    = START;
                    cnt_d      = CNT_LOAD;
                    bit_idx_d  = '0;
                    data_d     = ui_in;
                    checksum_d = checksum_q + ui_in;
                    busy_d     = 1'b1;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                    cnt_d   = CNT_LOAD;
                    tx_d    = data_q[0];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    cnt_d = CNT_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
`ifdef COLORFLYX_UART_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                        tx_d      = data_q[bit_idx_d];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef COLORFLYX_UART_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_d = STOP;
                    cnt_d   = CNT_LOAD;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        uio_out           = '0;
        uio_out[TX_BIT]   = tx_q;
        uio_out[BUSY_BIT] = busy_q;
        uio_out[DONE_BIT] = done_q;
    end

    assign uo_out = checksum_q;
    assign uio_oe = UIO_OE_MASK;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in[7:1]};

endmodule

// File: tb/tb_tt_um_colorflyx_sum_uart_tx.sv
// Self-checking bench for tt_um_colorflyx_sum_uart_tx with CLKS_PER_BIT=4.
module tb_tt_um_colorflyx_sum_uart_tx;
    import tt_colorflyx_uart_pkg::*;

    localparam int CPB = 4;
`ifdef COLORFLYX_UART_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR = 1'b1;
    localparam int FRAME_LIT = 44;
`else
    localparam int NBITS = 10;
    localparam bit PAR = 1'b0;
    localparam int FRAME_LIT = 40;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tt_um_colorflyx_sum_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    // Reference model: frame start time, captured byte and running sum.
    logic [3:0] hist;
    int         ecyc;
    int         m_start;
    logic       m_active;
    logic [7:0] m_byte;
    logic [7:0] m_sum;
    wire        m_launch = hist[2] & ~hist[3];
    wire        m_idle   = !m_active || (ecyc >= m_start + FRAME + 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist     <= '0;
            ecyc     <= 0;
            m_start  <= 0;
            m_active <= 1'b0;
            m_byte   <= '0;
            m_sum    <= '0;
        end else begin
            ecyc <= ecyc + 1;
            hist <= {hist[2:0], uio_in[0]};
            if (m_launch && m_idle) begin
                m_start  <= ecyc;
                m_active <= 1'b1;
                m_byte   <= ui_in;
                m_sum    <= m_sum + ui_in;
            end
        end
    end

    function automatic logic [7:0] exp_uio();
        int   k;
        int   b;
        logic t;
        logic bz;
        logic d;
        t  = 1'b1;
        bz = 1'b0;
        d  = 1'b0;
        if (m_active) begin
            k = ecyc - 1 - m_start;
            if (k < FRAME) begin
                bz = 1'b1;
                b  = k / CPB;
                if (b == 0)               t = 1'b0;
                else if (b <= 8)          t = m_byte[b-1];
                else if (PAR && b == 9)   t = ^m_byte;
                else                      t = 1'b1;
            end else begin
                d = (k == FRAME);
            end
        end
        return {4'b0000, d, bz, t, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare all outputs against the model.
    task automatic tick();
        @(negedge clk);
        chk("uio_out", 32'(uio_out), 32'(exp_uio()));
        chk("uo_out", 32'(uo_out), 32'(m_sum));
        chk("uio_oe", 32'(uio_oe), 32'h0E);
    endtask

    task automatic frame(input logic [7:0] b, input int rep, input logic [7:0] rep_byte,
                         output int lat, output logic [10:0] bits,
                         output int busy_len, output int dones);
        ui_in     = b;
        uio_in[0] = 1'b1;
        lat       = 0;
        bits      = '0;
        busy_len  = 0;
        dones     = 0;
        while (uio_out[TX_BIT] === 1'b1 && lat < 20) begin
            tick();
            lat++;
            if (lat == 2) uio_in[0] = 1'b0;
        end
        uio_in[0] = 1'b0;
        for (int j = 0; j <= FRAME + 3; j++) begin
            if (j == 0) ui_in = ~b;
            if (j == rep) begin
                ui_in     = rep_byte;
                uio_in[0] = 1'b1;
            end
            if (j == rep + 2) uio_in[0] = 1'b0;
            if (j <= FRAME && uio_out[BUSY_BIT]) busy_len++;
            if ((j % CPB) == 0 && (j / CPB) < 11) bits[j/CPB] = uio_out[TX_BIT];
            if (uio_out[DONE_BIT]) dones++;
            tick();
        end
    endtask

    int         lat;
    logic [10:0] bits;
    int         blen;
    int         dn;
    int         cnt;
    logic       prev_busy;

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = '0;
        uio_in = '0;
        tick();
        tick();
        chk("reset_uio_out", 32'(uio_out), 32'h02);
        chk("reset_uo_out", 32'(uo_out), 32'h00);
        rst_n = 1'b1;
        repeat (3) tick();

        // Single frame 0xA5
        frame(8'hA5, -1, 8'h00, lat, bits, blen, dn);
        chk("a5_latency", 32'(lat), 32'd4);
`ifdef COLORFLYX_UART_PARITY_EN
        chk("a5_bits", 32'(bits), 32'b101_0100_1010);
`else
        chk("a5_bits", 32'(bits), 32'b111_0100_1010);
`endif
        chk("a5_busy_len", 32'(blen), 32'(FRAME_LIT));
        chk("a5_done_cnt", 32'(dn), 32'd1);
        chk("a5_sum", 32'(uo_out), 32'hA5);

        // Asynchronous reset in the middle of a frame
        ui_in     = 8'h3C;
        uio_in[0] = 1'b1;
        tick();
        tick();
        uio_in[0] = 1'b0;
        repeat (12) tick();
        chk("pre_reset_sum", 32'(uo_out), 32'hE1);
        chk("pre_reset_busy", 32'(uio_out[BUSY_BIT]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(uio_out[TX_BIT]), 32'd1);
        chk("async_rst_busy", 32'(uio_out[BUSY_BIT]), 32'd0);
        chk("async_rst_sum", 32'(uo_out), 32'h00);
        chk("async_rst_oe", 32'(uio_oe), 32'h0E);
        tick();
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (uio_out[BUSY_BIT]) cnt++;
        end
        chk("no_retry_busy", 32'(cnt), 32'd0);

        // Checksum wrap
        frame(8'hF0, -1, 8'h00, lat, bits, blen, dn);
        chk("f0_sum", 32'(uo_out), 32'hF0);
        frame(8'h20, -1, 8'h00, lat, bits, blen, dn);
        chk("wrap_sum", 32'(uo_out), 32'h10);

        // Relaunch while busy is dropped
        frame(8'h11, 5, 8'h55, lat, bits, blen, dn);
        chk("drop_busy_len", 32'(blen), 32'(FRAME_LIT));
        chk("drop_sum", 32'(uo_out), 32'h21);

        // Launch landing on the STOP-completion cycle is dropped
        frame(8'h22, FRAME - 4, 8'h55, lat, bits, blen, dn);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (uio_out[BUSY_BIT]) cnt++;
        end
        chk("edge_drop_busy", 32'(cnt), 32'd0);
        chk("edge_drop_sum", 32'(uo_out), 32'h43);

        // Launch one cycle later is accepted
        frame(8'h30, FRAME - 3, 8'h55, lat, bits, blen, dn);
        chk("edge_acc_busy", 32'(uio_out[BUSY_BIT]), 32'd1);
        repeat (50) tick();
        chk("edge_acc_sum", 32'(uo_out), 32'hC8);

        // Held strobe gives exactly one frame
        ui_in     = 8'h01;
        uio_in[0] = 1'b1;
        cnt       = 0;
        for (int i = 0; i < 100; i++) begin
            prev_busy = uio_out[BUSY_BIT];
            tick();
            if (!prev_busy && uio_out[BUSY_BIT]) cnt++;
        end
        uio_in[0] = 1'b0;
        repeat (10) tick();
        chk("held_frames", 32'(cnt), 32'd1);
        chk("held_sum", 32'(uo_out), 32'hC9);

        // Frame length with 0x07 (parity bit 1 when enabled)
        frame(8'h07, -1, 8'h00, lat, bits, blen, dn);
        chk("b07_busy_len", 32'(blen), 32'(FRAME_LIT));
        chk("b07_bits", 32'(bits), 32'b110_0000_1110);
        chk("b07_sum", 32'(uo_out), 32'hD0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
